// File: rtl/boot_pkg.sv
// boot_pkg: shared types and constants for the boot loader.
package boot_pkg;
   localparam int WORD_W = 15;
   localparam int HOLD_W = 4;
   typedef enum logic [3:0] {
      S_IDLE, S_LEN, S_HI, S_LO, S_WRITE, S_CSUM, S_RELEASE, S_RUN, S_ERROR
   } boot_state_t;
endpackage

// File: rtl/mux2.sv
// mux2: two-input bus select, b_i when sel_i is high.
module mux2 #(
   parameter int W = 1
) (
   input  logic         sel_i,
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   output logic [W-1:0] y_o
);
   assign y_o = sel_i ? b_i : a_i;
endmodule

// File: rtl/rst_hold_ctr.sv
// rst_hold_ctr: loadable down-counter that stops at zero and flags it.
module rst_hold_ctr
   import boot_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              load_i,
   input  logic              en_i,
   input  logic [HOLD_W-1:0] val_i,
   output logic              zero_o
);
   logic [HOLD_W-1:0] cnt_q, cnt_d;
   always_comb cnt_d = load_i ? val_i : (en_i && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
   always_ff @(posedge clk_i) begin
      if (rst_i) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end
   assign zero_o = cnt_q == '0;
endmodule

// File: rtl/boot_loader.sv
// boot_loader: owns the memory port during a framed byte-stream load,
// then releases the core and passes its stores through.
module boot_loader
   import boot_pkg::*;
#(
   parameter logic [7:0] BASE_ADR = 8'h00,
   parameter int         RST_HOLD = 2
) (
   input  logic              ph1,
   input  logic              reset,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [7:0]        in_data,
   input  logic              cpu_memwrite,
   input  logic [7:0]        cpu_adr,
   input  logic [7:0]        cpu_wdata,
   output logic              cpu_reset,
   output logic              mem_we,
   output logic [7:0]        mem_adr,
   output logic [WORD_W-1:0] mem_wdata,
   output logic              busy,
   output logic              done,
   output logic              err
);
   boot_state_t       state_q, state_d;
   logic [7:0]        addr_q, addr_d, sum_q, sum_d, rem_q, rem_d, wadr_q, wadr_d;
   logic [6:0]        hi_q, hi_d;
   logic [WORD_W-1:0] wdat_q, wdat_d;
   logic              xfer, run, hold_zero, csum_ok;

   assign run      = state_q == S_RUN;
   assign in_ready = state_q inside {S_LEN, S_HI, S_LO, S_CSUM};
   assign xfer     = in_valid & in_ready;
   assign csum_ok  = state_q == S_CSUM && xfer && in_data == sum_q;
   assign busy     = state_q inside {S_LEN, S_HI, S_LO, S_WRITE, S_CSUM, S_RELEASE};
   assign done     = run;
   assign err      = state_q == S_ERROR;
   assign cpu_reset = !run;

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      sum_d   = sum_q;
      rem_d   = rem_q;
      hi_d    = hi_q;
      wadr_d  = wadr_q;
      wdat_d  = wdat_q;
      case (state_q)
         S_IDLE, S_RUN, S_ERROR: if (start) begin
            state_d = S_LEN;
            addr_d  = BASE_ADR;
            sum_d   = '0;
            rem_d   = '0;
         end
         S_LEN: if (xfer) begin
            sum_d   = in_data;
            rem_d   = in_data;
            state_d = in_data == '0 ? S_ERROR : S_HI;
         end
         S_HI: if (xfer) begin
            hi_d    = in_data[6:0];
            sum_d   = sum_q + in_data;
            state_d = in_data[7] ? S_ERROR : S_LO;
         end
         // The write address/data are latched here so WRITE drives them from registers.
         S_LO: if (xfer) begin
            wadr_d  = addr_q;
            wdat_d  = {hi_q, in_data};
            sum_d   = sum_q + in_data;
            state_d = S_WRITE;
         end
         S_WRITE: begin
            addr_d  = addr_q + 8'd1;
            rem_d   = rem_q - 8'd1;
            state_d = rem_q == 8'd1 ? S_CSUM : S_HI;
         end
         S_CSUM:    if (xfer) state_d = csum_ok ? S_RELEASE : S_ERROR;
         S_RELEASE: if (hold_zero) state_d = S_RUN;
         default:   state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge ph1) begin
      if (reset) begin
         state_q <= S_IDLE;
         addr_q  <= BASE_ADR;
         sum_q   <= '0;
         rem_q   <= '0;
         hi_q    <= '0;
         wadr_q  <= '0;
         wdat_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         sum_q   <= sum_d;
         rem_q   <= rem_d;
         hi_q    <= hi_d;
         wadr_q  <= wadr_d;
         wdat_q  <= wdat_d;
      end
   end

   rst_hold_ctr u_hold (
      .clk_i  (ph1),
      .rst_i  (reset),
      .load_i (csum_ok),
      .en_i   (state_q == S_RELEASE),
      .val_i  (HOLD_W'(RST_HOLD)),
      .zero_o (hold_zero)
   );

   mux2 #(.W(1)) u_we (
      .sel_i (run), .a_i (state_q == S_WRITE), .b_i (cpu_memwrite), .y_o (mem_we)
   );
   mux2 #(.W(8)) u_adr (
      .sel_i (run), .a_i (wadr_q), .b_i (cpu_adr), .y_o (mem_adr)
   );
   mux2 #(.W(WORD_W)) u_wdat (
      .sel_i (run), .a_i (wdat_q), .b_i ({7'b0, cpu_wdata}), .y_o (mem_wdata)
   );
endmodule

// File: tb/tb_boot_loader.sv
// tb_boot_loader: table, hand-written and random frames against a frame-level model,
// run on two loaders (base 00 and base FE) sharing one stimulus.
module tb_boot_loader;
   logic        ph1 = 0, reset = 1, start = 0, in_valid = 0, cpu_memwrite = 0;
   logic [7:0]  in_data = 0, cpu_adr = 0, cpu_wdata = 0;
   logic        in_ready_a, cpu_reset_a, mem_we_a, busy_a, done_a, err_a;
   logic        in_ready_b, cpu_reset_b, mem_we_b, busy_b, done_b, err_b;
   logic [7:0]  mem_adr_a, mem_adr_b;
   logic [14:0] mem_wdata_a, mem_wdata_b;

   always #5 ph1 = ~ph1;

   boot_loader #(.BASE_ADR(8'h00), .RST_HOLD(2)) dut_a (
      .ph1(ph1), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready_a),
      .in_data(in_data), .cpu_memwrite(cpu_memwrite), .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata),
      .cpu_reset(cpu_reset_a), .mem_we(mem_we_a), .mem_adr(mem_adr_a), .mem_wdata(mem_wdata_a),
      .busy(busy_a), .done(done_a), .err(err_a)
   );
   boot_loader #(.BASE_ADR(8'hFE), .RST_HOLD(2)) dut_b (
      .ph1(ph1), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready_b),
      .in_data(in_data), .cpu_memwrite(cpu_memwrite), .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata),
      .cpu_reset(cpu_reset_b), .mem_we(mem_we_b), .mem_adr(mem_adr_b), .mem_wdata(mem_wdata_b),
      .busy(busy_b), .done(done_b), .err(err_b)
   );

   int tests = 0, fails = 0;
   logic [22:0] got_a[$], got_b[$], exp_a[$], exp_b[$];
   logic [7:0]  frame[$];
   int          exp_consume;
   bit          exp_err;

   typedef struct {
      logic [0:7][7:0] b;
      int              n;
      bit              err;
      int              nw;
   } vec_t;
   vec_t vt[7];

   always @(negedge ph1) begin
      if (mem_we_a) got_a.push_back({mem_adr_a, mem_wdata_a});
      if (mem_we_b) got_b.push_back({mem_adr_b, mem_wdata_b});
      if (mem_we_a && !done_a) begin
         tests++;
         if (in_ready_a) begin
            fails++;
            $display("FAIL ready_in_write act=1 exp=0 t=%0t", $time);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Frame-level reference: expected writes for both bases, outcome and bytes consumed.
   function automatic void model();
      int idx;
      logic [7:0] s;
      logic [14:0] d;
      exp_a.delete();
      exp_b.delete();
      exp_err = 1;
      exp_consume = 1;
      if (frame[0] == 0) return;
      idx = 1;
      for (int w = 0; w < int'(frame[0]); w++) begin
         exp_consume = idx + 1;
         if (frame[idx][7]) return;
         exp_consume = idx + 2;
         d = {frame[idx][6:0], frame[idx+1]};
         exp_a.push_back({8'(w), d});
         exp_b.push_back({8'(254 + w), d});
         idx += 2;
      end
      exp_consume = idx + 1;
      s = 0;
      for (int i = 0; i < idx; i++) s = s + frame[i];
      exp_err = frame[idx] != s;
   endfunction

   task automatic send_byte(input logic [7:0] b, input bit rnd);
      int n = 0;
      bit sent = 0;
      while (!sent && n < 100) begin
         in_valid     = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         in_data      = in_valid ? b : 8'($urandom);
         cpu_memwrite = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
         cpu_adr      = 8'($urandom);
         cpu_wdata    = 8'($urandom);
         @(negedge ph1);
         sent = in_valid & in_ready_a;
         @(posedge ph1);
         #1;
         n++;
      end
      in_valid = 0;
      cpu_memwrite = 0;
      if (!sent) begin
         tests++;
         fails++;
         $display("FAIL send_timeout byte=%0h act=not_accepted exp=accepted", b);
      end
   endtask

   task automatic pulse_start();
      start = 1;
      @(posedge ph1);
      #1;
      start = 0;
   endtask

   task automatic run_frame(input bit rnd, input int glitch);
      int n = 0;
      model();
      got_a.delete();
      got_b.delete();
      pulse_start();
      chk("busy_after_start", busy_a, 1);
      chk("cpu_reset_loading", cpu_reset_a, 1);
      for (int i = 0; i < exp_consume; i++) begin
         if (i == glitch) pulse_start();
         send_byte(frame[i], rnd);
      end
      while (!(done_a | err_a) && n < 20) begin
         @(posedge ph1);
         #1;
         n++;
      end
      chk("end_err_a", err_a, exp_err);
      chk("end_done_a", done_a, !exp_err);
      chk("end_err_b", err_b, exp_err);
      chk("end_cpu_reset", cpu_reset_a, exp_err);
      chk("nwrites_a", got_a.size(), exp_a.size());
      chk("nwrites_b", got_b.size(), exp_b.size());
      for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) chk("write_a", got_a[i], exp_a[i]);
      for (int i = 0; i < exp_b.size() && i < got_b.size(); i++) chk("write_b", got_b[i], exp_b[i]);
   endtask

   initial begin
      logic [7:0] s, l, h;
      vt[0] = '{b: 64'h02_12_34_7F_FF_C6_00_00, n: 6, err: 0, nw: 2};
      vt[1] = '{b: 64'h02_12_34_7F_FF_C7_00_00, n: 6, err: 1, nw: 2};
      vt[2] = '{b: 64'h00_00_00_00_00_00_00_00, n: 1, err: 1, nw: 0};
      vt[3] = '{b: 64'h02_80_00_00_00_00_00_00, n: 2, err: 1, nw: 0};
      vt[4] = '{b: 64'h03_00_01_00_02_00_03_09, n: 8, err: 0, nw: 3};
      vt[5] = '{b: 64'h01_7F_FF_7F_00_00_00_00, n: 4, err: 0, nw: 1};
      vt[6] = '{b: 64'h02_12_34_85_00_00_00_00, n: 5, err: 1, nw: 1};

      in_valid = 1;
      in_data = 8'h55;
      repeat (3) @(posedge ph1);
      #1;
      chk("rst_cpu_reset", cpu_reset_a, 1);
      chk("rst_in_ready", in_ready_a, 0);
      chk("rst_mem_we", mem_we_a, 0);
      chk("rst_mem_adr", mem_adr_a, 0);
      chk("rst_mem_wdata", mem_wdata_a, 0);
      chk("rst_busy", busy_a, 0);
      chk("rst_done", done_a, 0);
      chk("rst_err", err_a, 0);
      reset = 0;
      repeat (3) @(posedge ph1);
      #1;
      chk("idle_ignores_valid", busy_a, 0);
      chk("idle_in_ready", in_ready_a, 0);
      in_valid = 0;

      // Release timing: C6 accepted at edge t, cpu_reset first low after edge t+3.
      got_a.delete();
      pulse_start();
      foreach (vt[0].b[j]) if (j < 5) send_byte(vt[0].b[j], 0);
      send_byte(8'hC6, 0);
      for (int k = 0; k < 4; k++) begin
         @(negedge ph1);
         chk("release_cpu_reset", cpu_reset_a, k < 3);
         chk("release_done", done_a, k == 3);
      end
      chk("t1_nwrites", got_a.size(), 2);
      if (got_a.size() == 2) begin
         chk("t1_write0", got_a[0], {8'h00, 15'h1234});
         chk("t1_write1", got_a[1], {8'h01, 15'h7FFF});
      end

      // RUN pass-through, then restart blocks the core.
      @(posedge ph1);
      #1;
      cpu_memwrite = 1;
      cpu_adr = 8'h40;
      cpu_wdata = 8'hA5;
      #1;
      chk("run_mem_we", mem_we_a, 1);
      chk("run_mem_adr", mem_adr_a, 8'h40);
      chk("run_mem_wdata", mem_wdata_a, 15'h00A5);
      chk("run_mem_adr_b", mem_adr_b, 8'h40);
      pulse_start();
      chk("restart_cpu_reset", cpu_reset_a, 1);
      chk("restart_mem_we", mem_we_a, 0);
      chk("restart_busy", busy_a, 1);
      cpu_memwrite = 0;

      for (int pass = 0; pass < 2; pass++)
         foreach (vt[k]) begin
            frame.delete();
            for (int j = 0; j < vt[k].n; j++) frame.push_back(vt[k].b[j]);
            run_frame(pass == 1, -1);
            chk("tbl_err", err_a, vt[k].err);
            chk("tbl_nwrites", got_a.size(), vt[k].nw);
         end

      // Reset while LO byte is being presented: the word is never written.
      pulse_start();
      send_byte(8'h01, 0);
      send_byte(8'h12, 0);
      got_a.delete();
      in_valid = 1;
      in_data = 8'h34;
      reset = 1;
      @(posedge ph1);
      #1;
      reset = 0;
      in_valid = 0;
      chk("midrst_busy", busy_a, 0);
      chk("midrst_cpu_reset", cpu_reset_a, 1);
      chk("midrst_in_ready", in_ready_a, 0);
      repeat (3) @(posedge ph1);
      #1;
      chk("midrst_nwrites", got_a.size(), 0);
      chk("midrst_mem_adr", mem_adr_a, 0);

      // start while in HI and while in LO is ignored.
      frame = '{8'h01, 8'h12, 8'h34, 8'h47};
      run_frame(0, 1);
      run_frame(0, 2);

      for (int r = 0; r < 40; r++) begin
         frame.delete();
         l = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom_range(1, 4));
         frame.push_back(l);
         s = l;
         for (int w = 0; w < int'(l); w++) begin
            h = ($urandom_range(0, 9) == 0) ? (8'($urandom) | 8'h80) : 8'($urandom_range(0, 127));
            frame.push_back(h);
            s = s + h;
            h = 8'($urandom);
            frame.push_back(h);
            s = s + h;
         end
         frame.push_back(($urandom_range(0, 3) == 0) ? 8'($urandom) : s);
         run_frame(1, -1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/boot_loader.md
Name: boot_loader

Overview:
Controller that owns the instruction/data memory port during boot and then hands it to the core.
- Holds the processor core in reset.
- Accepts a framed byte stream (length, word pairs, checksum) and writes 15-bit instruction words into memory starting at BASE_ADR.
- On a good checksum, releases core reset and passes core memory writes through.
- On any framing error, keeps the core parked in reset.

Parameters:
BASE_ADR, 8'h00, first memory address written by a load; address wraps 8'hFF->8'h00.
RST_HOLD, 2, cycles (1..15) that cpu_reset stays high in RELEASE after a good checksum.
WORD_W, 15, instruction word width (bits 14:0).

Ports:
ph1  in  1  single clock, all state updates on rising edge.
reset  in  1  synchronous, active-high.
start  in  1  begin/restart load session; sampled in IDLE, ERROR, RUN only.
in_valid  in  1  host byte valid.
in_ready  out  1  loader accepts byte; transfer = in_valid & in_ready.
in_data  in  8  host byte.
cpu_memwrite  in  1  core store strobe.
cpu_adr  in  8  core address.
cpu_wdata  in  8  core store data.
cpu_reset  out  1  reset to core.
mem_we  out  1  memory write enable.
mem_adr  out  8  memory address.
mem_wdata  out  WORD_W  memory write data.
busy  out  1  load in progress (LEN..RELEASE).
done  out  1  high in RUN.
err  out  1  high in ERROR.

Behaviour:
- Clocking: one clock, ph1; reset is synchronous and active-high.
- Reset values: state IDLE, cpu_reset 1, in_ready 0, mem_we 0, mem_adr 0, mem_wdata 0, busy 0, done 0, err 0.
- Reset mid-load: abort to IDLE; the in-flight word is not written.
- States: IDLE, LEN, HI, LO, WRITE, CSUM, RELEASE, RUN, ERROR.
- IDLE/ERROR/RUN + start: go to LEN; clear addr to BASE_ADR, clear sum and count; cpu_reset=1 from the next cycle.
- start in any other state is ignored.
- in_ready=1 only in LEN, HI, LO, CSUM. It is 0 in WRITE, RELEASE, IDLE, RUN, ERROR.
- LEN: accept byte L; sum=L; remaining=L.
  - L==0 -> ERROR.
  - Otherwise -> HI.
- HI: accept byte; bit7 set -> ERROR; else hi=byte[6:0], sum+=byte -> LO.
- LO: accept byte; lo=byte; sum+=byte -> WRITE.
- WRITE: exactly one cycle, registered outputs.
  - mem_we=1, mem_adr=addr, mem_wdata={hi,lo}.
  - Then addr+=1 (8-bit wrap) and remaining-=1.
  - Next state HI if remaining!=0, else CSUM.
- CSUM: accept byte.
  - byte==sum (8-bit, mod 256) -> RELEASE.
  - Else -> ERROR.
- RELEASE: cpu_reset=1 for RST_HOLD cycles, then RUN.
  - Checksum accepted at edge t -> cpu_reset first low at edge t+1+RST_HOLD.
- RUN: cpu_reset=0, done=1.
  - Combinational pass-through: mem_we=cpu_memwrite, mem_adr=cpu_adr, mem_wdata={7'b0,cpu_wdata}.
  - Outside RUN, cpu_* inputs are ignored and mem_we comes only from WRITE.
- ERROR: cpu_reset=1, err=1, mem_we=0; held until start or reset.
- In states other than WRITE and RUN: mem_we=0; mem_adr/mem_wdata hold the last WRITE values (0 after reset).
- in_valid without in_ready: no effect. Bytes are never dropped or duplicated.
- Address wrap: BASE_ADR=8'hFE, L=3 writes FE, FF, 00. L up to 255; no overflow error.

Decomposition:
- Package boot_pkg: state enum boot_state_t, WORD_W, RST_HOLD width constant.
- One sub-module, rst_hold_ctr: 4-bit down-counter with load, done flag, sync reset; used for RELEASE.
- The RUN-mode bus select uses the existing mux2.

Test Plan:
1. Reset 3 cycles -> all outputs at reset values, cpu_reset=1, in_ready=0. Then start, stream 02,12,34,7F,FF,C6:
   - mem_we pulses adr 00 data 15'h1234 and adr 01 data 15'h7FFF.
   - cpu_reset falls 3 edges after C6 accepted (RST_HOLD=2); done=1.
2. Same frame with checksum C7 -> ERROR, err=1, cpu_reset stays 1, exactly 2 writes occurred. Then start plus the good frame -> RUN.
3. Errors -> ERROR with no write for that word, in both cases:
   - L=00.
   - First HI byte 0x80.
4. BASE_ADR=FE, L=3 with words 0001,0002,0003 (checksum 09) -> writes at FE, FF, 00. in_valid toggled randomly (~50%) -> identical writes; in_ready=0 during each WRITE cycle.
5. In RUN, cpu_memwrite=1, cpu_adr=40, cpu_wdata=A5 -> same cycle mem_we=1, mem_adr=40, mem_wdata=15'h00A5. Assert start -> cpu_reset=1 next cycle and core writes are blocked.
6. Reset asserted in LO after HI accepted -> IDLE next cycle, no mem_we, cpu_reset=1. start during HI -> ignored.
